// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a combinational instruction memory,
// and buffers {pc, ins} in a 2-entry FIFO toward decode. Optional perf counters: IFETCH_PERF_EN.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_ins,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] head_pc;
  logic [31:0] head_ins;
  logic [31:0] tail_pc;
  logic [31:0] tail_ins;
  logic        pop;
  logic        push;
  logic        redirect;
  logic        unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign mem_addr  = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head_pc;
  assign out_ins   = head_ins;
  assign halted    = (state == HALT);

  // Redirect outranks everything and is dropped entirely while idle.
  always_comb begin
    redirect = redirect_valid && (state != IDLE);
    pop      = out_valid && out_ready;
    push     = (state == RUN) && !redirect && ((count != 2'd2) || pop);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (redirect)                          state_next = RUN;
        else if (push && (mem_ins == HALT_INSN)) state_next = HALT;
      end
      HALT: if (redirect) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Head is always entry 0; a pop shifts the tail forward so order is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      count    <= 2'd0;
      head_pc  <= '0;
      head_ins <= '0;
      tail_pc  <= '0;
      tail_ins <= '0;
    end else if (redirect) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      count <= 2'd0;
    end else begin
      if (push) pc <= pc + 32'd4;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc  <= pc;
            head_ins <= mem_ins;
          end else begin
            tail_pc  <= pc;
            tail_ins <= mem_ins;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc  <= tail_pc;
          head_ins <= tail_ins;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc  <= pc;
            head_ins <= mem_ins;
          end else begin
            head_pc  <= tail_pc;
            head_ins <= tail_ins;
            tail_pc  <= pc;
            tail_ins <= mem_ins;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (push)                    fetch_q <= fetch_q + 32'd1;
      if (out_valid && !out_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed, table-driven bench for ifetch_ctrl with a combinational memory model.
module tb_ifetch_ctrl;

  typedef struct {
    logic        rst;
    logic        start;
    logic        rdy;
    logic        rdv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] e_addr;
    logic        e_halt;
    logic        chk_cnt;
    logic [31:0] e_fetch;
    logic [31:0] e_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_addr, mem_ins, out_ins, out_pc, fetch_cnt, stall_cnt;
  logic        out_valid, halted;

  logic        start2 = 1'b0;
  logic [31:0] mem_addr2, mem_ins2, out_ins2, out_pc2, fetch_cnt2, stall_cnt2;
  logic        out_valid2, halted2;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  assign mem_ins  = mem[mem_addr[7:2]];
  assign mem_ins2 = mem[mem_addr2[7:2]];

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_ins(mem_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  ifetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .HALT_INSN(32'hFFFF_FFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mem_addr(mem_addr2), .mem_ins(mem_ins2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_ins(out_ins2), .out_pc(out_pc2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halted(halted2),
    .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic st, input logic rdy,
                              input logic rdv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] eins,
                              input logic [31:0] eaddr, input logic eh,
                              input logic cc, input logic [31:0] ef, input logic [31:0] es);
    vec_t v;
    v.rst = rst; v.start = st; v.rdy = rdy; v.rdv = rdv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_ins = eins; v.e_addr = eaddr; v.e_halt = eh;
    v.chk_cnt = cc; v.e_fetch = ef; v.e_stall = es;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_ins", out_ins, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fetch", fetch_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.rst) do_reset();
    else @(negedge clk);
    start = v.start; out_ready = v.rdy; redirect_valid = v.rdv; redirect_pc = v.rpc;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid", idx), {31'd0, out_valid}, {31'd0, v.e_valid});
    if (v.e_valid) begin
      chk($sformatf("v%0d_pc", idx), out_pc, v.e_pc);
      chk($sformatf("v%0d_ins", idx), out_ins, v.e_ins);
    end
    chk($sformatf("v%0d_addr", idx), mem_addr, v.e_addr);
    chk($sformatf("v%0d_halted", idx), {31'd0, halted}, {31'd0, v.e_halt});
`ifdef IFETCH_PERF_EN
    if (v.chk_cnt) begin
      chk($sformatf("v%0d_fetch_cnt", idx), fetch_cnt, v.e_fetch);
      chk($sformatf("v%0d_stall_cnt", idx), stall_cnt, v.e_stall);
    end
`else
    chk($sformatf("v%0d_fetch_cnt", idx), fetch_cnt, 32'd0);
    chk($sformatf("v%0d_stall_cnt", idx), stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] exp2_pc [0:3];
    logic [31:0] exp2_ins [0:3];
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    // streaming with out_ready held high
    vecs.push_back(mk(1,1,1,0,0, 0,0,0,32'h0,0, 1,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h0,32'h11,32'h4,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h4,32'h22,32'h8,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h8,32'h33,32'hC,0, 1,3,0));
    // backpressure fill/hold, then drain in order
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,32'h0,0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h0,32'h11,32'h4,0, 0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,0,0, 1,32'h0,32'h11,32'h8,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h0,32'h11,32'h8,0, 1,2,5));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h4,32'h22,32'hC,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h8,32'h33,32'h10,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'hC,32'h44,32'h14,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h10,32'hA000_0010,32'h18,0, 0,0,0));
    // redirect to unaligned 0x41 with 0x10/0x14 buffered
    vecs.push_back(mk(0,0,0,1,32'h41, 0,0,0,32'h40,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h40,32'hA000_0040,32'h44,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h44,32'hA000_0044,32'h48,0, 1,8,6));
    vecs.push_back(mk(0,0,1,0,0, 1,32'h48,32'hA000_0048,32'h4C,0, 0,0,0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // halt sentinel at 0x0C, start ignored in HALT, redirect resumes
    mem[3] = 32'hFFFF_FFFF;
    run_vec(mk(1,1,1,0,0, 0,0,0,32'h0,0, 0,0,0), 100);
    run_vec(mk(0,0,1,0,0, 1,32'h0,32'h11,32'h4,0, 0,0,0), 101);
    run_vec(mk(0,0,1,0,0, 1,32'h4,32'h22,32'h8,0, 0,0,0), 102);
    run_vec(mk(0,0,1,0,0, 1,32'h8,32'h33,32'hC,0, 0,0,0), 103);
    run_vec(mk(0,0,1,0,0, 1,32'hC,32'hFFFF_FFFF,32'h10,1, 0,0,0), 104);
    run_vec(mk(0,0,1,0,0, 0,0,0,32'h10,1, 0,0,0), 105);
    run_vec(mk(0,1,1,0,0, 0,0,0,32'h10,1, 0,0,0), 106);
    run_vec(mk(0,0,1,1,32'h0, 0,0,0,32'h0,0, 0,0,0), 107);
    run_vec(mk(0,0,1,0,0, 1,32'h0,32'h11,32'h4,0, 1,5,0), 108);
    mem[3] = 32'h44;

    // asynchronous reset with a full buffer, then IDLE ignores redirect
    run_vec(mk(1,1,0,0,0, 0,0,0,32'h0,0, 0,0,0), 200);
    run_vec(mk(0,0,0,0,0, 1,32'h0,32'h11,32'h4,0, 0,0,0), 201);
    run_vec(mk(0,0,0,0,0, 1,32'h0,32'h11,32'h8,0, 0,0,0), 202);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    chk("async_rst_fetch", fetch_cnt, 32'd0);
    #1;
    rst_n = 1'b1;
    run_vec(mk(0,0,1,0,0, 0,0,0,32'h0,0, 0,0,0), 203);
    run_vec(mk(0,0,1,1,32'h80, 0,0,0,32'h0,0, 0,0,0), 204);
    run_vec(mk(0,0,1,0,0, 0,0,0,32'h0,0, 1,0,0), 205);

    // PC wrap from a high reset vector on the second instance
    exp2_pc[0]  = 32'hFFFF_FFF8; exp2_pc[1]  = 32'hFFFF_FFFC; exp2_pc[2]  = 32'h0; exp2_pc[3]  = 32'h4;
    exp2_ins[0] = 32'hA000_00F8; exp2_ins[1] = 32'hA000_00FC; exp2_ins[2] = 32'h11; exp2_ins[3] = 32'h22;
    @(negedge clk);
    chk("wrap_idle_addr", mem_addr2, 32'hFFFF_FFF8);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    chk("wrap_start_valid", {31'd0, out_valid2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_valid", i), {31'd0, out_valid2}, 32'd1);
      chk($sformatf("wrap%0d_pc", i), out_pc2, exp2_pc[i]);
      chk($sformatf("wrap%0d_ins", i), out_ins2, exp2_ins[i]);
      chk($sformatf("wrap%0d_addr", i), mem_addr2, exp2_pc[i+1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
